palette_fade_ctrl: RTL
======================

Name: palette_fade_ctrl

Overview:
Writable 16-entry, 12-bit RGB palette with a frame-synchronous brightness fade sequencer. It sits between the sprite/background index generators and the VGA colour outputs, and replaces fixed per-asset palette ROMs where fade-in and fade-out transitions are needed. Brightness steps change only on frame boundaries, so a frame never tears mid-screen.

Parameters:
FRAMES_PER_STEP, 2, number of frame_start pulses per brightness step (legal range 1..255).

Ports:
clk  in  1  system/pixel clock
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  single-cycle pulse at start of vertical blank
wr_en  in  1  palette write strobe
wr_index  in  4  palette entry to write
wr_rgb  in  12  {R,G,B} nibbles to write
fade_out_req  in  1  single-cycle request: fade from current level to 0
fade_in_req  in  1  single-cycle request: fade from current level to 15
pix_index  in  4  palette index to look up
red  out  4  scaled red channel
green  out  4  scaled green channel
blue  out  4  scaled blue channel
level  out  4  current brightness level (0..15)
busy  out  1  high while a fade is in progress
done  out  1  single-cycle pulse when a fade completes

Behaviour:
- Reset (async, rst_n=0):
  - Entry i = {i,i,i} (grey ramp).
  - red/green/blue=0, level=15, busy=0, done=0.
  - State IDLE, frame counter=0.
- Storage: 16x12 registers.
  - Write on clk edge when wr_en=1.
  - Allowed in any state; never blocked by a fade.
- Lookup: pix_index is sampled at edge N; red/green/blue are valid after edge N+1 (1-cycle registered latency).
  - The lookup uses the storage contents and level held before edge N. A write to the same index at edge N is visible from the next lookup onward (read-old-data).
- Scaling, per channel: out = floor(c*level/15), with an 8-bit intermediate.
  - level=15 returns c exactly; level=0 returns 0.
- FSM states: IDLE, FADE_OUT, FADE_IN.
  - IDLE + fade_out_req:
    - level>0: go to FADE_OUT, busy=1 next cycle, counter cleared.
    - level=0: stay IDLE, pulse done next cycle.
  - IDLE + fade_in_req: symmetric (target 15).
  - Both requests in the same cycle: fade_out_req wins; fade_in_req is dropped.
  - Requests arriving while busy=1 are ignored. They are not queued.
  - In FADE_*, on each frame_start:
    - counter==FRAMES_PER_STEP-1: level steps by 1 (down for FADE_OUT, up for FADE_IN) and counter returns to 0.
    - Otherwise: counter increments.
  - Cycles without frame_start change nothing.
  - When the stepped level reaches its target (0 or 15), at the same edge: state goes to IDLE, busy=0 and done=1 for exactly one cycle.
  - A frame_start in the same cycle as a request does not count toward the new fade. Counting starts with the next frame_start.
- level holds its value in IDLE. A fade-in after a partial state resumes from the current level.
- Reset asserted mid-fade: everything returns immediately to the reset values above, including the palette contents. No done pulse.

Test Plan:
1. Release reset, pix_index=5 -> next cycle red/green/blue=5/5/5, level=15, busy=0.
2. wr_en with wr_index=3, wr_rgb=0xA5F, then pix_index=3 -> 0xA/0x5/0xF. Write index 3 and look up index 3 in the same cycle -> old value 3/3/3, then 0xA/0x5/0xF on the following lookup.
3. FRAMES_PER_STEP=2, fade_out_req, 16 frame_start pulses -> level=7 and entry 3 reads 4/2/7. After 30 pulses total -> level=0, done pulses once, busy falls in the same cycle, and all outputs are 0.
4. From level 0: fade_in_req and fade_out_req asserted together -> fade_out wins, done pulses next cycle, level stays 0. Then fade_in_req alone -> level=15 after 30 frame_start pulses.
5. During FADE_OUT at level 9, pulse fade_in_req -> ignored, fade continues down. Assert rst_n=0 mid-fade -> level=15, busy=0, entry 3 back to 3/3/3, no done pulse.
6. FRAMES_PER_STEP=1 with no frame_start for 1000 cycles after fade_out_req -> level stays 15 and busy stays 1. Each subsequent frame_start decrements level by exactly 1.

Source files
------------

// File: rtl/palette_fade_ctrl.sv
// 16-entry writable 12-bit RGB palette with registered lookup and a
// frame-synchronous brightness fade sequencer.
module palette_fade_ctrl #(
   parameter int FRAMES_PER_STEP = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_start,
   input  logic        wr_en,
   input  logic [3:0]  wr_index,
   input  logic [11:0] wr_rgb,
   input  logic        fade_out_req,
   input  logic        fade_in_req,
   input  logic [3:0]  pix_index,
   output logic [3:0]  red,
   output logic [3:0]  green,
   output logic [3:0]  blue,
   output logic [3:0]  level,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FADE_OUT = 2'd1,
      FADE_IN  = 2'd2
   } state_t;

   localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_STEP - 1);

   state_t      state;
   logic [7:0]  frame_cnt;
   logic [11:0] pal [16];
   logic [11:0] entry;

   // c*level peaks at 225, so an 8-bit product never overflows
   function automatic logic [3:0] scale(input logic [3:0] c, input logic [3:0] l);
      logic [7:0] prod;
      prod = 8'(c) * 8'(l);
      return 4'(prod / 8'd15);
   endfunction

   assign entry = pal[pix_index];

   // Palette storage and registered lookup; the lookup sees pre-edge
   // contents and level, so same-cycle writes read old data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) begin
            pal[i] <= {4'(i), 4'(i), 4'(i)};
         end
         red   <= 4'd0;
         green <= 4'd0;
         blue  <= 4'd0;
      end else begin
         if (wr_en) begin
            pal[wr_index] <= wr_rgb;
         end
         red   <= scale(entry[11:8], level);
         green <= scale(entry[7:4], level);
         blue  <= scale(entry[3:0], level);
      end
   end

   // Fade sequencer: level only moves on frame_start, and done fires on
   // the same edge that lands on the target
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         frame_cnt <= 8'd0;
         level     <= 4'd15;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (fade_out_req) begin
                  if (level != 4'd0) begin
                     state     <= FADE_OUT;
                     busy      <= 1'b1;
                     frame_cnt <= 8'd0;
                  end else begin
                     done <= 1'b1;
                  end
               end else if (fade_in_req) begin
                  if (level != 4'd15) begin
                     state     <= FADE_IN;
                     busy      <= 1'b1;
                     frame_cnt <= 8'd0;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            FADE_OUT: begin
               if (frame_start) begin
                  if (frame_cnt == LAST_FRAME) begin
                     frame_cnt <= 8'd0;
                     level     <= level - 4'd1;
                     if (level == 4'd1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end else begin
                     frame_cnt <= frame_cnt + 8'd1;
                  end
               end
            end
            FADE_IN: begin
               if (frame_start) begin
                  if (frame_cnt == LAST_FRAME) begin
                     frame_cnt <= 8'd0;
                     level     <= level + 4'd1;
                     if (level == 4'd14) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end else begin
                     frame_cnt <= frame_cnt + 8'd1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
